// File: rtl/iterative_divider_if.sv
// Handshake bundle for the iterative divider: request side (master) and divider side (slave).
// state_dbg mirrors the divider FSM so checkers can bind to it without reaching into the design.
interface iterative_divider_if #(
    parameter int n = 32
);
    logic         start;
    logic [n-1:0] a;
    logic [n-1:0] b;
    logic         is_signed;
    logic         busy;
    logic         done;
    logic [n-1:0] quotient;
    logic [n-1:0] remainder;
    logic         div_by_zero;
    logic [1:0]   state_dbg;

    // start is a one-cycle request taken only while busy==0; done is a
    // one-cycle pulse and results hold until the next completed operation.
    modport master (
        output start, a, b, is_signed,
        input  busy, done, quotient, remainder, div_by_zero, state_dbg
    );

    modport slave (
        input  start, a, b, is_signed,
        output busy, done, quotient, remainder, div_by_zero, state_dbg
    );
endinterface

// File: rtl/iterative_divider.sv
// Multi-cycle restoring shift-subtract divider, one quotient bit per cycle.
// Optional signed (DIV) support is compiled in with the SIGNED_DIV_EN macro.
module iterative_divider #(
    parameter int n = 32
) (
    input logic               clk,
    input logic               rst,
    iterative_divider_if.slave bus
);
    localparam int cw = $clog2(n);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t        state;
    logic [n-1:0]  dvd;
    logic [n-1:0]  rem;
    logic [n-1:0]  dvs;
    logic [cw-1:0] count;
    logic          dbz;

    logic [n:0]    pr;
    logic [n-1:0]  sub;
    logic          ge;
    logic          accept;
    logic [n-1:0]  a_mag;
    logic [n-1:0]  b_mag;
    logic [n-1:0]  q_fix;
    logic [n-1:0]  r_fix;

`ifdef SIGNED_DIV_EN
    logic neg_q;
    logic neg_r;
    logic a_neg;
    logic b_neg;
`else
    logic unused_is_signed;
    assign unused_is_signed = bus.is_signed;
`endif

    assign bus.state_dbg = state;

    always_comb begin
        accept = bus.start && (state != RUN);
        pr     = {rem, dvd[n-1]};
        ge     = (pr >= {1'b0, dvs});
        // When ge holds the difference is below dvs, so n bits suffice.
        sub    = pr[n-1:0] - dvs;
`ifdef SIGNED_DIV_EN
        a_neg  = bus.is_signed && bus.a[n-1];
        b_neg  = bus.is_signed && bus.b[n-1];
        a_mag  = a_neg ? -bus.a : bus.a;
        b_mag  = b_neg ? -bus.b : bus.b;
        q_fix  = neg_q ? -dvd : dvd;
        r_fix  = neg_r ? -rem : rem;
`else
        a_mag  = bus.a;
        b_mag  = bus.b;
        q_fix  = dvd;
        r_fix  = rem;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.quotient    <= '0;
            bus.remainder   <= '0;
            bus.div_by_zero <= 1'b0;
            dvd             <= '0;
            rem             <= '0;
            dvs             <= '0;
            count           <= '0;
            dbz             <= 1'b0;
`ifdef SIGNED_DIV_EN
            neg_q           <= 1'b0;
            neg_r           <= 1'b0;
`endif
        end else begin
            bus.done <= 1'b0;
            case (state)
                RUN: begin
                    rem <= ge ? sub : pr[n-1:0];
                    dvd <= {dvd[n-2:0], ge};
                    if (count == '0) begin
                        state    <= FIN;
                        bus.busy <= 1'b0;
                    end else begin
                        count <= count - cw'(1);
                    end
                end
                FIN: begin
                    // Sign fix-up is folded into this output load, no extra cycle.
                    bus.done        <= 1'b1;
                    bus.quotient    <= q_fix;
                    bus.remainder   <= r_fix;
                    bus.div_by_zero <= dbz;
                    state           <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // A start taken in FIN overrides the IDLE return but the old
            // result still lands on the outputs above.
            if (accept) begin
                dvs <= b_mag;
                dbz <= (bus.b == '0);
                if (bus.b == '0) begin
                    dvd   <= '1;
                    rem   <= bus.a;
                    state <= FIN;
`ifdef SIGNED_DIV_EN
                    neg_q <= 1'b0;
                    neg_r <= 1'b0;
`endif
                end else begin
                    dvd      <= a_mag;
                    rem      <= '0;
                    count    <= cw'(n - 1);
                    state    <= RUN;
                    bus.busy <= 1'b1;
`ifdef SIGNED_DIV_EN
                    neg_q    <= a_neg ^ b_neg;
                    neg_r    <= a_neg;
`endif
                end
            end
        end
    end
endmodule

// File: tb/tb_iterative_divider.sv
// Bench for iterative_divider: directed vector table, hand-written corner
// sequences and random operations checked against an arithmetic model.
module tb_iterative_divider;
  localparam int N = 32;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         s;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dbz;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  iterative_divider_if #(.n(N)) dif();
  iterative_divider #(.n(N)) dut (
    .clk(clk),
    .rst(rst),
    .bus(dif)
  );

  int total  = 0;
  int passed = 0;
  logic [N-1:0] exp_q[$];

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    else passed++;
  endtask

  // Arithmetic reference: returns {dbz, quotient, remainder}.
  function automatic logic [2*N:0] model(input logic [N-1:0] a, input logic [N-1:0] b, input logic s);
    logic [N-1:0] q;
    logic [N-1:0] r;
    if (b == '0) return {1'b1, {N{1'b1}}, a};
`ifdef SIGNED_DIV_EN
    if (s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = a;
        r = '0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
      return {1'b0, q, r};
    end
`endif
    q = a / b;
    r = a % b;
    return {1'b0, q, r};
  endfunction

  // Drives a one-cycle start; returns #1 after the accepting edge.
  task automatic launch(input logic [N-1:0] a, input logic [N-1:0] b, input logic s);
    @(negedge clk);
    dif.start     = 1'b1;
    dif.a         = a;
    dif.b         = b;
    dif.is_signed = s;
    @(posedge clk);
    #1 dif.start = 1'b0;
  endtask

  // lat = edges after the accepting edge until done is seen (-1 on timeout).
  task automatic wait_done(output int lat, output int bcnt);
    lat  = -1;
    bcnt = dif.busy ? 1 : 0;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk);
      #1;
      if (dif.done) begin
        lat = k;
        break;
      end
      if (dif.busy) bcnt++;
    end
  endtask

  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic s,
                        output int lat, output int bcnt);
    launch(a, b, s);
    wait_done(lat, bcnt);
  endtask

  vec_t vecs[8];

  initial begin
    int lat;
    int bcnt;
    int pulses;
    logic [2*N:0] m;

    vecs[0] = '{32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0};
    vecs[1] = '{32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0};
    vecs[2] = '{32'd5, 32'd9, 1'b0, 32'd0, 32'd5, 1'b0};
    vecs[3] = '{32'd1234, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd1234, 1'b1};
`ifdef SIGNED_DIV_EN
    vecs[4] = '{32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0};
    vecs[5] = '{32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0};
    vecs[6] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0};
`else
    vecs[4] = '{32'hFFFF_FFF9, 32'd2, 1'b1, 32'h7FFF_FFFC, 32'd1, 1'b0};
    vecs[5] = '{32'd7, 32'hFFFF_FFFE, 1'b1, 32'd0, 32'd7, 1'b0};
    vecs[6] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'h8000_0000, 1'b0};
`endif
    vecs[7] = '{32'hFFFF_FFF9, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1};

    // Reset block
    rst           = 1'b1;
    dif.start     = 1'b0;
    dif.a         = '0;
    dif.b         = '0;
    dif.is_signed = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", N'(dif.busy), 0);
    check("reset done", N'(dif.done), 0);
    check("reset quotient", dif.quotient, 0);
    check("reset remainder", dif.remainder, 0);
    check("reset dbz", N'(dif.div_by_zero), 0);
    @(negedge clk);
    rst = 1'b0;

    // Reset mid-run: operation abandoned, no done pulse
    launch(32'd100, 32'd7, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrun reset busy", N'(dif.busy), 0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (dif.done) pulses++;
    end
    check("midrun reset no done", N'(pulses), 0);
    check("midrun reset quotient", dif.quotient, 0);

    // Directed vector table
    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].s, lat, bcnt);
      check($sformatf("vec%0d quotient", i), dif.quotient, vecs[i].q);
      check($sformatf("vec%0d remainder", i), dif.remainder, vecs[i].r);
      check($sformatf("vec%0d dbz", i), N'(dif.div_by_zero), N'(vecs[i].dbz));
      check($sformatf("vec%0d latency", i), N'(lat), vecs[i].dbz ? 1 : N + 1);
      check($sformatf("vec%0d busy cycles", i), N'(bcnt), vecs[i].dbz ? 0 : N);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d done width", i), N'(dif.done), 0);
      repeat (5) @(posedge clk);
      #1;
      check($sformatf("vec%0d hold quotient", i), dif.quotient, vecs[i].q);
    end

    // start while busy is ignored
    launch(32'd100, 32'd7, 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    dif.start = 1'b1;
    dif.a     = 32'd1;
    dif.b     = 32'd1;
    @(posedge clk);
    #1 dif.start = 1'b0;
    wait_done(lat, bcnt);
    check("busy start latency", N'(lat < 0 ? -1 : lat + 6), N + 1);
    check("busy start quotient", dif.quotient, 32'd14);
    check("busy start remainder", dif.remainder, 32'd2);

    // start in the FIN cycle: old result pulses, new op follows
    launch(32'd100, 32'd7, 1'b0);
    lat = -1;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk);
      #1;
      if (!dif.busy) begin
        lat = c;
        break;
      end
    end
    check("fin cycle reached", N'(lat), N);
    check("fin cycle done low", N'(dif.done), 0);
    launch(32'd50, 32'd3, 1'b0);
    check("fin start old done", N'(dif.done), 1);
    check("fin start old quotient", dif.quotient, 32'd14);
    check("fin start busy", N'(dif.busy), 1);
    wait_done(lat, bcnt);
    check("fin start new latency", N'(lat), N + 1);
    check("fin start new quotient", dif.quotient, 32'd16);
    check("fin start new remainder", dif.remainder, 32'd2);

    // Random operations against the model
    for (int i = 0; i < 150; i++) begin
      logic [N-1:0] ra;
      logic [N-1:0] rb;
      logic         rs;
      int           sel;
      ra  = $urandom;
      sel = $urandom_range(0, 9);
      case (sel)
        0:       rb = '0;
        1, 2, 3: rb = N'($urandom_range(1, 15));
        4:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) ra = 32'h8000_0000;
      rs = 1'($urandom_range(0, 1));
      m  = model(ra, rb, rs);
      exp_q.push_back(m[2*N-1:N]);
      run_op(ra, rb, rs, lat, bcnt);
      check($sformatf("rand%0d quotient a=%08h b=%08h s=%0d", i, ra, rb, rs), dif.quotient, exp_q.pop_front());
      check($sformatf("rand%0d remainder", i), dif.remainder, m[N-1:0]);
      check($sformatf("rand%0d dbz", i), N'(dif.div_by_zero), N'(m[2*N]));
      check($sformatf("rand%0d latency", i), N'(lat), m[2*N] ? 1 : N + 1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
